divider_sequencer: RTL
======================

Name: divider_sequencer

Overview:
- Operand front-end for the multi-cycle fixed-point divider. It accepts signed dividend/divisor pairs on a valid/ready stream and buffers them in a small FIFO.
- It issues one single-cycle start pulse to the divider per operation, holds the operands stable until the divider's result strobe, then presents the quotient on a valid/ready output stream.
- It bypasses divide-by-zero and times out a hung divider, so the single-pulse, no-ready divider can sit inside a backpressured datapath.

Parameters:
- DIVIDEND, 32, dividend and quotient width (bits, signed)
- DIVISOR, 24, divisor width (bits, signed)
- DEPTH, 4, operand FIFO entries (power of 2, >=2)
- TIMEOUT, 64, max cycles in WAIT before the op is abandoned (>=2)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- s_valid  in  1  operand pair valid
- s_ready  out  1  FIFO can accept; equals !full
- s_dividend  in  DIVIDEND  signed dividend
- s_divisor  in  DIVISOR  signed divisor
- div_ivalid  out  1  one-cycle start pulse to divider
- div_dividend  out  DIVIDEND  operand to divider, held stable ISSUE..WAIT
- div_divisor  out  DIVISOR  operand to divider, held stable ISSUE..WAIT
- div_ovalid  in  1  divider result strobe
- div_quotient  in  DIVIDEND  divider result
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_quotient  out  DIVIDEND  result quotient
- m_dbz  out  1  result was a divide-by-zero bypass
- m_timeout  out  1  result was a timeout
- busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (async, any state):
  - FIFO empties and state goes to IDLE.
  - All outputs are 0, except s_ready=1 once reset deasserts.
  - The watchdog counter is cleared.
  - An in-flight divider result is discarded.
- FIFO:
  - Push on s_valid&&s_ready. No push when full, even if a pop occurs the same cycle.
  - Pop happens only in IDLE.
  - Entries are issued in order. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - If the FIFO is non-empty, pop into the operand registers.
  - If the popped divisor is 0, go to HOLD with the bypass result; otherwise go to ISSUE.
  - If the FIFO is empty, stay in IDLE.
- ISSUE:
  - div_ivalid=1 for exactly this one cycle; the counter is cleared.
  - Go to WAIT next cycle.
- WAIT:
  - The counter increments each cycle.
  - On div_ovalid, capture div_quotient into m_quotient, set m_dbz=0 and m_timeout=0, and go to HOLD.
  - If the counter reaches TIMEOUT without div_ovalid, set m_quotient=0 and m_timeout=1, and go to HOLD.
- HOLD:
  - m_valid=1. m_quotient, m_dbz and m_timeout are stable while m_ready=0.
  - On m_ready, clear m_valid and go to IDLE.
  - Throughput: one op per (divider latency + 3) cycles with m_ready tied high.
- Divide-by-zero bypass:
  - Dividend >= 0 gives m_quotient = max positive (0x7FFFFFFF at defaults).
  - Dividend < 0 gives m_quotient = min negative (0x80000000).
  - m_dbz=1. m_valid asserts the cycle after the pop. No div_ivalid is issued.
- div_ovalid outside WAIT is ignored, including late strobes after a timeout.
- div_dividend and div_divisor are register outputs. They change only on a pop.
- Latency from a div_ovalid edge to m_valid high is 1 cycle.
- Sign handling is entirely the divider's. The quotient passes through unmodified.
- busy is combinational from state and FIFO count.

Test Plan:
- Basic op: push (100,5); divider BFM returns 20 after 36 cycles. Expect exactly one div_ivalid pulse with 100/5 on the operand outputs, then m_valid with m_quotient=20, m_dbz=0, m_timeout=0, one cycle after div_ovalid.
- Queueing and order: push (-100,5), (103,-5), (-100,-5), (0,5), (7,1) back-to-back with m_ready=0 initially.
  - s_ready drops only when the FIFO is full.
  - Once m_ready is released, results arrive in order: -20, -20, 20, 0, 7.
  - Exactly 5 div_ivalid pulses, none during WAIT or HOLD.
- Divide-by-zero: push (100,0) then (-7,0). Expect m_quotient=0x7FFFFFFF with m_dbz=1, then 0x80000000 with m_dbz=1, and zero div_ivalid pulses.
- Backpressure: result ready but m_ready=0 for 10 cycles. m_valid, m_quotient and flags stay stable, and the next queued op is not issued until the cycle after the m_ready handshake.
- Timeout: the BFM never strobes. After 64 WAIT cycles expect m_valid with m_quotient=0 and m_timeout=1. A div_ovalid injected afterwards changes nothing.
- Reset mid-op: assert reset during WAIT with 2 entries queued. Outputs go to 0 asynchronously, busy=0 and s_ready=1 after release, and the queued entries are never issued.

Source files
------------

// File: rtl/divider_sequencer_if.sv
// Stream bundle around the divider sequencer: operand input stream,
// divider start/result handshake, quotient output stream and status.
interface divider_sequencer_if #(
  parameter int DIVIDEND = 32,
  parameter int DIVISOR  = 24
);
  // operand input stream
  logic                s_valid;
  logic                s_ready;
  logic [DIVIDEND-1:0] s_dividend;
  logic [DIVISOR-1:0]  s_divisor;
  // divider side
  logic                div_ivalid;
  logic [DIVIDEND-1:0] div_dividend;
  logic [DIVISOR-1:0]  div_divisor;
  logic                div_ovalid;
  logic [DIVIDEND-1:0] div_quotient;
  // result output stream
  logic                m_valid;
  logic                m_ready;
  logic [DIVIDEND-1:0] m_quotient;
  logic                m_dbz;
  logic                m_timeout;
  // status
  logic                busy;

  // sequencer view
  modport slave (
    input  s_valid, s_dividend, s_divisor, div_ovalid, div_quotient, m_ready,
    output s_ready, div_ivalid, div_dividend, div_divisor,
           m_valid, m_quotient, m_dbz, m_timeout, busy
  );

  // environment view (producer, divider, consumer)
  modport master (
    output s_valid, s_dividend, s_divisor, div_ovalid, div_quotient, m_ready,
    input  s_ready, div_ivalid, div_dividend, div_divisor,
           m_valid, m_quotient, m_dbz, m_timeout, busy
  );
endinterface

// File: rtl/divider_sequencer.sv
// Operand front-end for a single-pulse, no-ready divider: buffers operand
// pairs, issues one start pulse per op, waits for the result strobe with a
// watchdog, bypasses divide-by-zero and presents results on a stream.
module divider_sequencer #(
  parameter int DIVIDEND = 32,
  parameter int DIVISOR  = 24,
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = 64
) (
  input logic                clock,
  input logic                reset,
  divider_sequencer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [PW:0]         FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0]       WD_LAST  = CW'(TIMEOUT - 1);
  localparam logic [DIVIDEND-1:0] Q_MAX    = {1'b0, {(DIVIDEND - 1){1'b1}}};
  localparam logic [DIVIDEND-1:0] Q_MIN    = {1'b1, {(DIVIDEND - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  // operand FIFO storage (no reset needed: occupancy is tracked by count_q)
  logic [DIVIDEND-1:0] mem_dd [DEPTH];
  logic [DIVISOR-1:0]  mem_dv [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  state_t              state_q;
  logic [CW-1:0]       wd_cnt_q;
  logic                div_ivalid_q;
  logic [DIVIDEND-1:0] div_dividend_q;
  logic [DIVISOR-1:0]  div_divisor_q;
  logic                m_valid_q;
  logic [DIVIDEND-1:0] m_quotient_q;
  logic                m_dbz_q;
  logic                m_timeout_q;

  logic                full;
  logic                push;
  logic                pop;
  logic [DIVIDEND-1:0] head_dd;
  logic [DIVISOR-1:0]  head_dv;

  // A full FIFO refuses a push even if IDLE pops in the same cycle, which
  // keeps s_ready independent of the FSM.
  assign full    = (count_q == FULL_CNT);
  assign push    = bus.s_valid && !full;
  assign pop     = (state_q == IDLE) && (count_q != '0);
  assign head_dd = mem_dd[rd_ptr_q];
  assign head_dv = mem_dv[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // Write incoming operand pairs into the slot addressed by the write pointer.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_dd[wr_ptr_q] <= bus.s_dividend;
      mem_dv[wr_ptr_q] <= bus.s_divisor;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sequencer FSM with all divider-side and result-side outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      wd_cnt_q       <= '0;
      div_ivalid_q   <= 1'b0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
      m_valid_q      <= 1'b0;
      m_quotient_q   <= '0;
      m_dbz_q        <= 1'b0;
      m_timeout_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            div_dividend_q <= head_dd;
            div_divisor_q  <= head_dv;
            if (head_dv == '0) begin
              // divide-by-zero never reaches the divider; saturate by sign
              state_q      <= HOLD;
              m_valid_q    <= 1'b1;
              m_quotient_q <= head_dd[DIVIDEND-1] ? Q_MIN : Q_MAX;
              m_dbz_q      <= 1'b1;
              m_timeout_q  <= 1'b0;
            end else begin
              state_q      <= ISSUE;
              div_ivalid_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          div_ivalid_q <= 1'b0;
          wd_cnt_q     <= '0;
          state_q      <= WAIT;
        end
        WAIT: begin
          wd_cnt_q <= wd_cnt_q + 1'b1;
          if (bus.div_ovalid) begin
            state_q      <= HOLD;
            m_valid_q    <= 1'b1;
            m_quotient_q <= bus.div_quotient;
            m_dbz_q      <= 1'b0;
            m_timeout_q  <= 1'b0;
          end else if (wd_cnt_q == WD_LAST) begin
            // abandon the op; a late strobe lands outside WAIT and is ignored
            state_q      <= HOLD;
            m_valid_q    <= 1'b1;
            m_quotient_q <= '0;
            m_dbz_q      <= 1'b0;
            m_timeout_q  <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_ready      = !full && !reset;
  assign bus.div_ivalid   = div_ivalid_q;
  assign bus.div_dividend = div_dividend_q;
  assign bus.div_divisor  = div_divisor_q;
  assign bus.m_valid      = m_valid_q;
  assign bus.m_quotient   = m_quotient_q;
  assign bus.m_dbz        = m_dbz_q;
  assign bus.m_timeout    = m_timeout_q;
  assign bus.busy         = (state_q != IDLE) || (count_q != '0);
endmodule
